instr_encoder: RTL and testbench

Sequential instruction encoder and program loader: the inverse of the core's control decoder. It accepts mnemonic-level instruction requests through a valid/ready handshake and buffers them in a small FIFO. Each request is encoded into a 9-bit machine word (3-bit opcode, 2-bit funct) and written to consecutive instruction-memory addresses. It sits between the test or boot sequencer and the instruction ROM/RAM write port.

---
 rtl/instr_encoder.sv | 154 +++++++++++++++
 tb/tb_instr_encoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder and program loader: buffers mnemonic-level requests in a
// small FIFO and writes encoded 9-bit words to consecutive memory addresses.
module instr_encoder #(
   parameter int PC_W   = 8,
   parameter int FIFO_D = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_mn,
   input  logic [1:0]      in_ra,
   input  logic [1:0]      in_rb,
   input  logic [5:0]      in_imm,
   output logic            imem_we,
   output logic [PC_W-1:0] imem_addr,
   output logic [8:0]      imem_wdata,
   output logic [PC_W:0]   instr_count,
   output logic            done,
   output logic            err_illegal,
   output logic            err_range
);

   localparam int AW = $clog2(FIFO_D);
   localparam logic [AW:0]     PTR_ONE  = (AW+1)'(1);
   localparam logic [PC_W-1:0] ADDR_ONE = PC_W'(1);
   localparam logic [PC_W:0]   CNT_ONE  = (PC_W+1)'(1);
   localparam logic [PC_W-1:0] ADDR_MAX = {PC_W{1'b1}};

   localparam logic [3:0] MN_LD    = 4'd8;
   localparam logic [3:0] MN_STR   = 4'd9;
   localparam logic [3:0] MN_ADDI  = 4'd10;
   localparam logic [3:0] MN_SHIFT = 4'd11;
   localparam logic [3:0] MN_JUMP  = 4'd12;
   localparam logic [3:0] MN_BEQ   = 4'd13;

   typedef struct packed {
      logic [3:0] mn;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [5:0] imm;
   } req_t;

   req_t        fifo_mem [FIFO_D];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;
   logic        last_wr;
   req_t        head;
   logic [8:0]  enc_word;
   logic        enc_ill;
   logic        enc_rng;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign in_ready = !fifo_full && !done && !start;
   assign push     = in_valid && in_ready;

   // The final word is still on the bus: popping now would wrap the address.
   assign last_wr  = imem_we && (imem_addr == ADDR_MAX);
   assign pop      = !fifo_empty && !done && !last_wr && !start;

   assign head = fifo_mem[rd_ptr[AW-1:0]];

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      enc_word = '0;
      enc_ill  = 1'b0;
      enc_rng  = 1'b0;
      case (head.mn)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
            enc_word = {2'b00, head.mn[2], head.mn[1:0], head.ra, head.rb};
         MN_LD: begin
            enc_word = {3'b010, head.ra, head.imm[3:0]};
            enc_rng  = |head.imm[5:4];
         end
         MN_STR: begin
            enc_word = {3'b011, head.ra, head.imm[3:0]};
            enc_rng  = |head.imm[5:4];
         end
         MN_ADDI: begin
            enc_word = {3'b100, head.ra, head.imm[3:0]};
            enc_rng  = |head.imm[5:4];
         end
         MN_SHIFT: begin
            enc_word = {3'b101, head.ra, head.imm[3:0]};
            enc_rng  = |head.imm[5:4];
         end
         MN_JUMP: enc_word = {3'b110, head.imm};
         MN_BEQ:  enc_word = {3'b111, head.imm};
         default: enc_ill  = 1'b1;
      endcase
   end

   // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{mn: in_mn, ra: in_ra, rb: in_rb, imm: in_imm};
   end

   // NOTE: all state below updates with non-blocking assignments so every flop
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         instr_count <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         err_range   <= 1'b0;
      end else if (start) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         instr_count <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         err_range   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

         imem_we <= 1'b0;
         if (imem_we) begin
            instr_count <= instr_count + CNT_ONE;
            if (!last_wr) imem_addr <= imem_addr + ADDR_ONE;
         end
         if (last_wr) done <= 1'b1;

         if (pop) begin
            if (enc_ill) begin
               err_illegal <= 1'b1;
            end else if (enc_rng) begin
               err_range <= 1'b1;
            end else begin
               imem_we    <= 1'b1;
               imem_wdata <= enc_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (PC_W=3): directed scenarios plus random
// streams scored against an arithmetic reference encoder and an in-order write queue.
module tb_instr_encoder;

   localparam int PC_W   = 3;
   localparam int FIFO_D = 4;
   localparam int CAP    = 1 << PC_W;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            start;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_mn;
   logic [1:0]      in_ra;
   logic [1:0]      in_rb;
   logic [5:0]      in_imm;
   logic            imem_we;
   logic [PC_W-1:0] imem_addr;
   logic [8:0]      imem_wdata;
   logic [PC_W:0]   instr_count;
   logic            done;
   logic            err_illegal;
   logic            err_range;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   int         wr_idx    = 0;
   bit         exp_ill   = 1'b0;
   bit         exp_rng   = 1'b0;
   int         exp_legal = 0;

   instr_encoder #(.PC_W(PC_W), .FIFO_D(FIFO_D)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mn(in_mn), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .instr_count(instr_count), .done(done),
      .err_illegal(err_illegal), .err_range(err_range)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference encoder built directly from the field-weight arithmetic of the word formats.
   function automatic void ref_encode(input int mn, input int ra, input int rb, input int imm,
                                      output bit legal, output bit ill, output bit rng,
                                      output logic [8:0] word);
      legal = 1'b0; ill = 1'b0; rng = 1'b0; word = '0;
      if (mn < 8) begin
         word  = 9'((mn / 4) * 64 + (mn % 4) * 16 + ra * 4 + rb);
         legal = 1'b1;
      end else if (mn < 12) begin
         if (imm >= 16) rng = 1'b1;
         else begin
            word  = 9'((mn - 6) * 64 + ra * 16 + imm);
            legal = 1'b1;
         end
      end else if (mn < 14) begin
         word  = 9'((mn - 6) * 64 + imm);
         legal = 1'b1;
      end else begin
         ill = 1'b1;
      end
   endfunction

   // Scoreboard: every write must be the next expected word at the next address.
   always @(negedge clk) begin
      if (reset_n && imem_we) begin
         check("wr_in_capacity", 32'(wr_idx < CAP), 1);
         check("wr_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            check("wr_data", 32'(imem_wdata), 32'(exp_q.pop_front()));
            check("wr_addr", 32'(imem_addr), 32'(wr_idx % CAP));
         end
         wr_idx++;
      end
   end

   task automatic flush_model();
      exp_q.delete();
      wr_idx    = 0;
      exp_ill   = 1'b0;
      exp_rng   = 1'b0;
      exp_legal = 0;
   endtask

   task automatic do_start();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      #1 check("start_ready_low", 32'(in_ready), 0);
      @(posedge clk);
      flush_model();
      #1 start = 1'b0;
      check("start_we", 32'(imem_we), 0);
      check("start_addr", 32'(imem_addr), 0);
      check("start_count", 32'(instr_count), 0);
      check("start_done", 32'(done), 0);
      check("start_errs", 32'({err_illegal, err_range}), 0);
   endtask

   // Present one request and hold it until accepted (bounded wait).
   task automatic send(input int mn, input int ra, input int rb, input int imm);
      int  waited = 0;
      bit  legal, ill, rng;
      logic [8:0] word;
      @(negedge clk);
      in_valid = 1'b1;
      in_mn    = 4'(mn);
      in_ra    = 2'(ra);
      in_rb    = 2'(rb);
      in_imm   = 6'(imm);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("send_timeout", 32'(in_ready), 1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         ref_encode(mn, ra, rb, imm, legal, ill, rng, word);
         if (legal) begin
            exp_q.push_back(word);
            exp_legal++;
         end
         exp_ill |= ill;
         exp_rng |= rng;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=0x0 exp=0x1");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      in_mn = '0; in_ra = '0; in_rb = '0; in_imm = '0;
      #1;
      check("rst_ready", 32'(in_ready), 1);
      check("rst_we", 32'(imem_we), 0);
      check("rst_addr", 32'(imem_addr), 0);
      check("rst_wdata", 32'(imem_wdata), 0);
      check("rst_count", 32'(instr_count), 0);
      check("rst_done", 32'(done), 0);
      check("rst_errs", 32'({err_illegal, err_range}), 0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;

      // Latency: accepted at edge N, written between N+1 and N+2.
      do_start();
      send(0, 1, 2, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check("lat_n_we", 32'(imem_we), 0);
      @(negedge clk);
      check("lat_n1_we", 32'(imem_we), 1);
      check("lat_n1_addr", 32'(imem_addr), 0);
      @(negedge clk);
      check("lat_n2_we", 32'(imem_we), 0);
      check("lat_n2_count", 32'(instr_count), 1);
      check("lat_n2_addr", 32'(imem_addr), 1);

      // Encode coverage, back-to-back.
      do_start();
      send(0, 1, 2, 0);
      send(5, 3, 0, 0);
      send(10, 2, 0, 5);
      send(12, 0, 0, 42);
      send(13, 0, 0, 63);
      idle(2);
      check("enc_count", 32'(instr_count), 5);
      check("enc_writes", 32'(wr_idx), 5);

      // Six consecutive requests: one write per cycle, none lost or duplicated.
      do_start();
      for (int i = 0; i < 6; i++) send($urandom_range(0, 7), $urandom % 4, $urandom % 4, 0);
      idle(2);
      check("tput_count", 32'(instr_count), 6);
      check("tput_writes", 32'(wr_idx), 6);
      check("tput_left", 32'(exp_q.size()), 0);

      // Illegal mnemonic and range error are dropped; only 'not r2' is written.
      do_start();
      send(14, 0, 0, 0);
      send(8, 1, 0, 18);
      send(2, 2, 0, 0);
      idle(2);
      check("err_illegal", 32'(err_illegal), 1);
      check("err_range", 32'(err_range), 1);
      check("err_count", 32'(instr_count), 1);
      check("err_writes", 32'(wr_idx), 1);

      // Random streams within capacity.
      for (int r = 0; r < 8; r++) begin
         int n;
         do_start();
         n = $urandom_range(1, 7);
         for (int i = 0; i < n; i++) begin
            send($urandom_range(0, 15), $urandom % 4, $urandom % 4, $urandom % 64);
            if ($urandom_range(0, 2) == 0) idle(1);
         end
         idle(3);
         check("rnd_count", 32'(instr_count), 32'(exp_legal));
         check("rnd_illegal", 32'(err_illegal), 32'(exp_ill));
         check("rnd_range", 32'(err_range), 32'(exp_rng));
         check("rnd_left", 32'(exp_q.size()), 0);
      end

      // Fill memory: 8 writes, then sticky done and two entries held.
      do_start();
      for (int i = 0; i < 10; i++) send($urandom_range(0, 7), $urandom % 4, $urandom % 4, 0);
      idle(4);
      check("full_done", 32'(done), 1);
      check("full_ready", 32'(in_ready), 0);
      check("full_count", 32'(instr_count), 8);
      check("full_addr", 32'(imem_addr), 7);
      check("full_writes", 32'(wr_idx), 8);
      check("full_held", 32'(exp_q.size()), 2);

      // start releases a full memory; next request lands at address 0.
      do_start();
      send(13, 0, 0, 5);
      idle(2);
      check("post_full_writes", 32'(wr_idx), 1);
      check("post_full_count", 32'(instr_count), 1);

      // start during an active stream cancels the pending write.
      do_start();
      send(1, 0, 1, 0);
      send(3, 2, 3, 0);
      send(6, 1, 1, 0);
      do_start();
      idle(3);
      check("flush_writes", 32'(wr_idx), 0);
      check("flush_count", 32'(instr_count), 0);

      // Asynchronous reset while a write is on the bus.
      do_start();
      send(9, 1, 0, 7);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1 check("arst_pre_we", 32'(imem_we), 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_we", 32'(imem_we), 0);
      check("arst_addr", 32'(imem_addr), 0);
      check("arst_wdata", 32'(imem_wdata), 0);
      check("arst_count", 32'(instr_count), 0);
      check("arst_ready", 32'(in_ready), 1);
      flush_model();
      @(posedge clk);
      #3 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("arst_no_write", 32'(instr_count), 0);
      check("arst_no_wr_seen", 32'(wr_idx), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
